// File: rtl/fixed_activation_stream_arbiter.sv
// Round-robin block arbiter that shares one elementwise activation unit between NUM_REQ streams.
// An in-order ID FIFO remembers which requester owns each block so results can be steered back.
module fixed_activation_stream_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int PARALLELISM  = 1,
    parameter int BLOCK_BEATS  = 10,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ*PARALLELISM*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    output logic [PARALLELISM*DATA_WIDTH-1:0]         act_data_in,
    output logic                                      act_data_in_valid,
    input  logic                                      act_data_in_ready,
    input  logic [PARALLELISM*DATA_WIDTH-1:0]         act_data_out,
    input  logic                                      act_data_out_valid,
    output logic                                      act_data_out_ready,
    output logic [NUM_REQ*PARALLELISM*DATA_WIDTH-1:0] resp_data,
    output logic [NUM_REQ-1:0]                        resp_valid,
    input  logic [NUM_REQ-1:0]                        resp_ready,
    output logic                                      busy
);

    localparam int BEAT_W = PARALLELISM * DATA_WIDTH;
    localparam int SEL_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
    localparam int PTR_W  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int FCNT_W = $clog2(MAX_INFLIGHT + 1);

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BLOCK_BEATS - 1);
    localparam logic [SEL_W-1:0]  LAST_REQ  = SEL_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(MAX_INFLIGHT - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(MAX_INFLIGHT);

    typedef enum logic {IDLE, BURST} state_e;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [SEL_W-1:0]  fifo_mem_q [MAX_INFLIGHT];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0] fifo_cnt_q;

    logic             grant_found;
    logic [SEL_W-1:0] winner;
    int               rr_idx;
    logic             grant;
    logic             in_hs;
    logic             out_hs;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [SEL_W-1:0] head;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign head       = fifo_mem_q[rd_ptr_q];
    assign in_hs      = act_data_in_valid && act_data_in_ready;
    assign out_hs     = act_data_out_valid && act_data_out_ready;
    assign resp_data  = {NUM_REQ{act_data_out}};
    assign busy       = (state_q == BURST) || !fifo_empty;

    // Search starts one past the previous winner, so the last owner has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        winner      = '0;
        rr_idx      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_idx = (32'(last_grant_q) + i) % NUM_REQ;
            if (!grant_found && req_valid[rr_idx[SEL_W-1:0]]) begin
                grant_found = 1'b1;
                winner      = rr_idx[SEL_W-1:0];
            end
        end
    end

    // Uses the pre-pop count: a slot freed this cycle is usable from the next one.
    assign grant = (state_q == IDLE) && grant_found && (fifo_cnt_q < FIFO_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_grant_q <= LAST_REQ;
            in_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            in_cnt_q     <= in_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        in_cnt_d     = in_cnt_q;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    sel_d        = winner;
                    last_grant_d = winner;
                    in_cnt_d     = '0;
                    push         = 1'b1;
                    state_d      = BURST;
                end
            end
            BURST: begin
                if (in_hs) begin
                    if (in_cnt_q == LAST_BEAT) begin
                        in_cnt_d = '0;
                        state_d  = IDLE;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        act_data_in        = '0;
        act_data_in_valid  = 1'b0;
        req_ready          = '0;
        resp_valid         = '0;
        act_data_out_ready = 1'b0;
        if (state_q == BURST) begin
            act_data_in       = req_data[sel_q*BEAT_W +: BEAT_W];
            act_data_in_valid = req_valid[sel_q];
            req_ready[sel_q]  = act_data_in_ready;
        end
        if (!fifo_empty) begin
            resp_valid[head]   = act_data_out_valid;
            act_data_out_ready = resp_ready[head];
        end
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        pop       = 1'b0;
        if (out_hs) begin
            if (out_cnt_q == LAST_BEAT) begin
                out_cnt_d = '0;
                pop       = 1'b1;
            end else begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            out_cnt_q <= out_cnt_d;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= winner;
        end
    end

endmodule

// File: tb/tb_fixed_activation_stream_arbiter.sv
// Bench for fixed_activation_stream_arbiter: two requesters, 4-beat blocks, two blocks in flight,
// with a queued identity model of the shared activation unit.
`timescale 1ns/1ps
module tb_fixed_activation_stream_arbiter;

    localparam int NR = 2;
    localparam int DW = 8;
    localparam int BB = 4;
    localparam int MI = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [DW-1:0] act_data_in;
    logic          act_data_in_valid;
    logic          act_data_in_ready;
    logic [DW-1:0] act_data_out;
    logic          act_data_out_valid;
    logic          act_data_out_ready;
    logic [NR*DW-1:0] resp_data;
    logic [NR-1:0] resp_valid;
    logic [NR-1:0] resp_ready;
    logic          busy;

    fixed_activation_stream_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .PARALLELISM(1), .BLOCK_BEATS(BB), .MAX_INFLIGHT(MI)
    ) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
        .act_data_in(act_data_in), .act_data_in_valid(act_data_in_valid),
        .act_data_in_ready(act_data_in_ready),
        .act_data_out(act_data_out), .act_data_out_valid(act_data_out_valid),
        .act_data_out_ready(act_data_out_ready),
        .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared unit model: registered queue, identity function, output gated by unit_en.
    logic          unit_en;
    logic [DW-1:0] u_mem [16];
    logic [3:0]    u_rd, u_wr;
    logic [4:0]    u_sz;

    always_comb begin
        act_data_in_ready  = (u_sz < 5'd16);
        act_data_out_valid = unit_en && (u_sz != 5'd0);
        act_data_out       = u_mem[u_rd];
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_rd <= '0;
            u_wr <= '0;
            u_sz <= '0;
        end else begin
            if (act_data_in_valid && act_data_in_ready) begin
                u_mem[u_wr] <= act_data_in;
                u_wr        <= u_wr + 4'd1;
            end
            if (act_data_out_valid && act_data_out_ready) u_rd <= u_rd + 4'd1;
            u_sz <= u_sz + 5'(act_data_in_valid && act_data_in_ready)
                         - 5'(act_data_out_valid && act_data_out_ready);
        end
    end

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [DW-1:0] src_val [NR];
    int            src_left [NR];
    logic [NR-1:0] en;
    logic [NR-1:0] rdy;
    logic          uen;
    logic [NR-1:0] pend_in;
    int            in_beats [NR];
    int            resp_cnt [NR];
    int            in_log [$];
    int            in_cyc [$];
    logic [DW-1:0] exp0 [$];
    logic [DW-1:0] exp1 [$];

    // One clock: apply effects of last cycle's handshakes, then observe at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < NR; r++) begin
            if (pend_in[r]) begin
                src_val[r]  = src_val[r] + 8'd1;
                src_left[r] = src_left[r] - 1;
            end
            req_valid[r]           = en[r] && (src_left[r] > 0);
            req_data[r*DW +: DW]   = src_val[r];
        end
        pend_in    = '0;
        resp_ready = rdy;
        unit_en    = uen;
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            if (req_valid[r] && req_ready[r]) begin
                pend_in[r] = 1'b1;
                if (r == 0) exp0.push_back(src_val[r]);
                else        exp1.push_back(src_val[r]);
                in_beats[r]++;
                in_log.push_back(r);
                in_cyc.push_back(cyc);
            end
            if (resp_valid[r] && resp_ready[r]) begin
                logic [DW-1:0] got;
                logic [DW-1:0] want;
                logic          have;
                got  = resp_data[r*DW +: DW];
                have = (r == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
                total++;
                if (!have) begin
                    bad++;
                    $display("FAIL resp_unexpected req=%0d got=%h want=none", r, got);
                end else begin
                    if (r == 0) want = exp0.pop_front();
                    else        want = exp1.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL resp_data req=%0d got=%h want=%h", r, got, want);
                    end
                end
                resp_cnt[r]++;
            end
        end
    endtask

    task automatic reset_dut();
        rst        = 1'b0;
        en         = '0;
        rdy        = '1;
        uen        = 1'b1;
        pend_in    = '0;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = '1;
        unit_en    = 1'b1;
        for (int r = 0; r < NR; r++) begin
            src_left[r] = 0;
            src_val[r]  = (r == 0) ? 8'h01 : 8'h81;
            in_beats[r] = 0;
            resp_cnt[r] = 0;
        end
        exp0.delete();
        exp1.delete();
        in_log.delete();
        in_cyc.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 200; k++) begin
            if (src_left[0] == 0 && src_left[1] == 0 && pend_in == '0 &&
                exp0.size() == 0 && exp1.size() == 0 && !busy) break;
            step();
        end
        total++;
        if (exp0.size() != 0 || exp1.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain got pending=%0d/%0d busy=%b want pending=0/0 busy=0",
                     name, exp0.size(), exp1.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        req_valid  = '1;
        req_data   = 16'h8101;
        resp_ready = '1;
        unit_en    = 1'b1;
        #2;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        total++; if (act_data_in_valid !== 1'b0) begin bad++; $display("FAIL reset_in_valid got=%b want=0", act_data_in_valid); end
        total++; if (act_data_in !== 8'h00) begin bad++; $display("FAIL reset_in_data got=%h want=00", act_data_in); end
        total++; if (act_data_out_ready !== 1'b0) begin bad++; $display("FAIL reset_out_ready got=%b want=0", act_data_out_ready); end
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b want=00", resp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        reset_dut();
        #1;
        total++; if (busy !== 1'b0 || req_ready !== 2'b00) begin bad++; $display("FAIL reset_release got busy=%b ready=%b want 0/00", busy, req_ready); end
    endtask

    task automatic test_single();
        logic rv1;
        rv1 = 1'b0;
        reset_dut();
        en[0]       = 1'b1;
        src_left[0] = 2 * BB;
        step();
        total++; if (req_ready !== 2'b00 || act_data_in_valid !== 1'b0) begin bad++; $display("FAIL single_arb_cycle got ready=%b valid=%b want 00/0", req_ready, act_data_in_valid); end
        step();
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_first_ready got=%b want=01", req_ready); end
        total++; if (act_data_in !== 8'h01) begin bad++; $display("FAIL single_first_data got=%h want=01", act_data_in); end
        for (int k = 0; k < 60 && resp_cnt[0] < 2 * BB; k++) begin
            step();
            if (resp_valid[1]) rv1 = 1'b1;
        end
        total++; if (resp_cnt[0] != 2 * BB) begin bad++; $display("FAIL single_resp_count got=%0d want=%0d", resp_cnt[0], 2 * BB); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_last got=%b want=1", busy); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
        total++; if (rv1 !== 1'b0) begin bad++; $display("FAIL single_resp1_valid got=%b want=0", rv1); end
        total++; if (in_beats[0] != 2 * BB) begin bad++; $display("FAIL single_in_beats got=%0d want=%0d", in_beats[0], 2 * BB); end
    endtask

    task automatic test_round_robin();
        reset_dut();
        en          = 2'b11;
        src_left[0] = 2 * BB;
        src_left[1] = 2 * BB;
        for (int k = 0; k < 80 && in_log.size() < 4 * BB; k++) step();
        total++;
        if (in_log.size() < 4 * BB) begin
            bad++;
            $display("FAIL rr_beats got=%0d want=%0d", in_log.size(), 4 * BB);
        end else begin
            for (int i = 0; i < 4 * BB; i++) begin
                total++;
                if (in_log[i] != (i / BB) % 2) begin bad++; $display("FAIL rr_owner beat=%0d got=%0d want=%0d", i, in_log[i], (i / BB) % 2); end
            end
            total++; if (in_cyc[BB-1] - in_cyc[0] != BB - 1) begin bad++; $display("FAIL rr_burst_len got=%0d want=%0d", in_cyc[BB-1] - in_cyc[0], BB - 1); end
            total++; if (in_cyc[BB] - in_cyc[BB-1] != 2) begin bad++; $display("FAIL rr_gap1 got=%0d want=2", in_cyc[BB] - in_cyc[BB-1]); end
            total++; if (in_cyc[2*BB] - in_cyc[2*BB-1] != 2) begin bad++; $display("FAIL rr_gap2 got=%0d want=2", in_cyc[2*BB] - in_cyc[2*BB-1]); end
        end
        drain("rr");
    endtask

    task automatic test_backpressure();
        int held;
        reset_dut();
        en[0]       = 1'b1;
        src_left[0] = BB;
        for (int k = 0; k < 20 && resp_cnt[0] < 1; k++) step();
        held   = resp_cnt[0];
        rdy[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            total++; if (act_data_out_ready !== 1'b0) begin bad++; $display("FAIL bp_out_ready cyc=%0d got=%b want=0", k, act_data_out_ready); end
        end
        total++; if (resp_cnt[0] != held || act_data_out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold got cnt=%0d valid=%b want cnt=%0d valid=1", resp_cnt[0], act_data_out_valid, held); end
        rdy[0] = 1'b1;
        drain("bp");
        total++; if (resp_cnt[0] != BB) begin bad++; $display("FAIL bp_resp_count got=%0d want=%0d", resp_cnt[0], BB); end
    endtask

    task automatic test_inflight();
        reset_dut();
        uen         = 1'b0;
        en          = 2'b11;
        src_left[0] = BB;
        src_left[1] = 2 * BB;
        repeat (25) step();
        total++; if (in_beats[0] != BB || in_beats[1] != BB) begin bad++; $display("FAIL inflight_accepted got=%0d/%0d want=%0d/%0d", in_beats[0], in_beats[1], BB, BB); end
        total++; if (req_ready !== 2'b00 || act_data_in_valid !== 1'b0) begin bad++; $display("FAIL inflight_no_third got ready=%b valid=%b want 00/0", req_ready, act_data_in_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL inflight_busy got=%b want=1", busy); end
        total++; if (act_data_out_ready !== 1'b1 || resp_valid !== 2'b00) begin bad++; $display("FAIL inflight_out got ready=%b rv=%b want 1/00", act_data_out_ready, resp_valid); end
        uen = 1'b1;
        for (int k = 0; k < 20 && resp_cnt[0] < BB; k++) step();
        step();
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL inflight_pop_cycle got=%b want=00", req_ready); end
        step();
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL inflight_third_grant got=%b want=10", req_ready); end
        drain("inflight");
    endtask

    task automatic test_async_reset();
        reset_dut();
        en          = 2'b11;
        src_left[0] = BB;
        src_left[1] = BB;
        for (int k = 0; k < 20 && in_beats[0] < 3; k++) step();
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL areset_pre got=%b want=01", req_ready); end
        #1;
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL areset_req_ready got=%b want=00", req_ready); end
        total++; if (act_data_in_valid !== 1'b0) begin bad++; $display("FAIL areset_in_valid got=%b want=0", act_data_in_valid); end
        total++; if (resp_valid !== 2'b00 || act_data_out_ready !== 1'b0) begin bad++; $display("FAIL areset_resp got rv=%b ordy=%b want 00/0", resp_valid, act_data_out_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b want=0", busy); end
        reset_dut();
        en          = 2'b11;
        src_left[0] = BB;
        src_left[1] = BB;
        step();
        step();
        total++;
        if (in_log.size() < 1 || in_log[0] != 0) begin
            bad++;
            $display("FAIL areset_first_grant got=%0d want=0", (in_log.size() < 1) ? -1 : in_log[0]);
        end
        drain("areset");
    endtask

    task automatic test_valid_gap();
        reset_dut();
        en          = 2'b11;
        src_left[0] = 2 * BB;
        src_left[1] = BB;
        for (int k = 0; k < 30 && in_beats[1] < 1; k++) step();
        en[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (act_data_in_valid !== 1'b0 || req_ready !== 2'b10) begin bad++; $display("FAIL gap_hold cyc=%0d got valid=%b ready=%b want 0/10", k, act_data_in_valid, req_ready); end
        end
        en[1] = 1'b1;
        for (int k = 0; k < 20 && in_beats[1] < BB; k++) step();
        total++;
        if (in_log.size() < 2 * BB) begin
            bad++;
            $display("FAIL gap_beats got=%0d want>=%0d", in_log.size(), 2 * BB);
        end else begin
            for (int i = BB; i < 2 * BB; i++) begin
                total++;
                if (in_log[i] != 1) begin bad++; $display("FAIL gap_owner beat=%0d got=%0d want=1", i, in_log[i]); end
            end
        end
        drain("gap");
        total++; if (in_beats[1] != BB || in_beats[0] != 2 * BB) begin bad++; $display("FAIL gap_counts got=%0d/%0d want=%0d/%0d", in_beats[0], in_beats[1], 2 * BB, BB); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_inflight();
        test_async_reset();
        test_valid_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
